// File: rtl/ldpc_llr_feeder_if.sv
// ldpc_llr_feeder_if
// Bundles the demapper-side LLR stream and the decoder-side frame stream
// of the LDPC input feeder.
//   master : the feeder itself (consumes llr_*/sof/rate/max_iter/dec_busy,
//            produces data_out/sync_out/rate_out/max_iter_out/ovf/frm_err)
//   slave  : the surrounding environment (demapper + decoder)
interface ldpc_llr_feeder_if #(
  parameter int D_WID = 6
);
  logic [D_WID-1:0] llr_in;
  logic             llr_vld;
  logic             sof_in;
  logic             rate_in;
  logic [4:0]       max_iter_in;
  logic             dec_busy;
  logic [D_WID-1:0] data_out;
  logic             sync_out;
  logic             rate_out;
  logic [4:0]       max_iter_out;
  logic             ovf;
  logic             frm_err;

  modport master (
    input  llr_in, llr_vld, sof_in, rate_in, max_iter_in, dec_busy,
    output data_out, sync_out, rate_out, max_iter_out, ovf, frm_err
  );

  modport slave (
    output llr_in, llr_vld, sof_in, rate_in, max_iter_in, dec_busy,
    input  data_out, sync_out, rate_out, max_iter_out, ovf, frm_err
  );
endinterface

// File: rtl/ldpc_llr_feeder.sv
// ldpc_llr_feeder
// Collects bursty LLRs into a two-bank ping-pong buffer and replays every
// complete frame to the LDPC decoder as one gap-free burst with sync_out
// held high for FRAME_LEN cycles. Rate and iteration limit travel with
// their frame.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   bus      : ldpc_llr_feeder_if.master
//              in : llr_in, llr_vld, sof_in, rate_in, max_iter_in, dec_busy
//              out: data_out, sync_out, rate_out, max_iter_out, ovf (sticky),
//                   frm_err (one-cycle pulse)
// Optional feature: define LLR_CLIP_EN to store the most negative LLR code
// as its negated maximum, giving the decoder a symmetric range.
module ldpc_llr_feeder #(
  parameter int D_WID     = 6,
  parameter int FRAME_LEN = 9216,
  parameter int AW        = 14,
  parameter int HOLD_CYC  = 2
) (
  input logic                clk,
  input logic                reset_n,
  ldpc_llr_feeder_if.master  bus
);

  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] N_CNT     = CW'(FRAME_LEN);
  // Read counter runs two past the last address so the read pipeline
  // drains before the bank is released.
  localparam logic [CW-1:0] DRAIN_END = CW'(FRAME_LEN + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [D_WID-1:0] MOST_NEG = {1'b1, {(D_WID-1){1'b0}}};

  typedef enum logic {WIDLE, WFILL} wr_state_t;
  typedef enum logic [1:0] {RIDLE, SEND, HOLD} rd_state_t;

  wr_state_t        wr_state_reg;
  logic [AW-1:0]    wr_addr_reg;
  logic             wr_bank_reg;
  logic             ovf_reg;
  logic             frm_err_reg;
  logic [1:0]       full_reg;
  logic [1:0]       bank_rate_reg;
  logic [1:0][4:0]  bank_iter_reg;

  rd_state_t        rd_state_reg;
  logic [CW-1:0]    rd_cnt_reg;
  logic             rd_bank_reg;
  logic [HW-1:0]    hold_cnt_reg;
  logic             rd_vld_reg;
  logic             sync_out_reg;
  logic [D_WID-1:0] data_out_reg;
  logic             rate_out_reg;
  logic [4:0]       max_iter_out_reg;

  logic             start_frame, drop_frame, mem_we, last_write;
  logic [AW-1:0]    mem_waddr;
  logic [D_WID-1:0] mem_wdata;
  logic             rd_en, rd_done;
  logic [AW-1:0]    rd_addr;
  logic [D_WID-1:0] rd_data;

`ifdef LLR_CLIP_EN
  assign mem_wdata = (bus.llr_in == MOST_NEG) ? (MOST_NEG | D_WID'(1)) : bus.llr_in;
`else
  assign mem_wdata = bus.llr_in;
`endif

  // Write-side decode. A start of frame always targets address 0, whether
  // it opens a frame in WIDLE or abandons a partial one in WFILL.
  always_comb begin
    start_frame = bus.llr_vld & bus.sof_in;
    drop_frame  = start_frame & full_reg[wr_bank_reg];
    mem_we      = (start_frame & ~full_reg[wr_bank_reg])
                | (bus.llr_vld & ~bus.sof_in & (wr_state_reg == WFILL));
    mem_waddr   = bus.sof_in ? '0 : wr_addr_reg;
    last_write  = bus.llr_vld & ~bus.sof_in & (wr_state_reg == WFILL)
                & (wr_addr_reg == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state_reg <= WIDLE;
      wr_addr_reg  <= '0;
      wr_bank_reg  <= 1'b0;
      ovf_reg      <= 1'b0;
      frm_err_reg  <= 1'b0;
    end else begin
      frm_err_reg <= start_frame & (wr_state_reg == WFILL);
      if (drop_frame) begin
        ovf_reg      <= 1'b1;
        wr_state_reg <= WIDLE;
      end else if (start_frame) begin
        wr_state_reg <= WFILL;
        wr_addr_reg  <= AW'(1);
      end else if (last_write) begin
        wr_state_reg <= WIDLE;
        wr_bank_reg  <= ~wr_bank_reg;
      end else if (mem_we) begin
        wr_addr_reg  <= wr_addr_reg + AW'(1);
      end
    end
  end

  // Bank status. Set and clear never hit the same bank in one cycle: the
  // writer only fills a bank that is not full, the reader only clears a
  // full one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_reg      <= '0;
      bank_rate_reg <= '0;
      bank_iter_reg <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (start_frame && !drop_frame && wr_bank_reg == 1'(b)) begin
          bank_rate_reg[b] <= bus.rate_in;
          bank_iter_reg[b] <= bus.max_iter_in;
        end
        if (last_write && wr_bank_reg == 1'(b))
          full_reg[b] <= 1'b1;
        else if (rd_done && rd_bank_reg == 1'(b))
          full_reg[b] <= 1'b0;
      end
    end
  end

  assign rd_en   = (rd_state_reg == SEND) && (rd_cnt_reg < N_CNT);
  assign rd_addr = rd_cnt_reg[AW-1:0];
  assign rd_done = (rd_state_reg == SEND) && (rd_cnt_reg == DRAIN_END);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [D_WID-1:0] mem [0:FRAME_LEN-1];
      logic [D_WID-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (mem_we && wr_bank_reg == 1'(gi))
          mem[mem_waddr] <= mem_wdata;
        if (rd_en && rd_bank_reg == 1'(gi))
          rd_q <= mem[rd_addr];
      end
    end
  endgenerate

  assign rd_data = rd_bank_reg ? g_bank[1].rd_q : g_bank[0].rd_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_state_reg     <= RIDLE;
      rd_cnt_reg       <= '0;
      rd_bank_reg      <= 1'b0;
      hold_cnt_reg     <= '0;
      rd_vld_reg       <= 1'b0;
      sync_out_reg     <= 1'b0;
      data_out_reg     <= '0;
      rate_out_reg     <= 1'b0;
      max_iter_out_reg <= '0;
    end else begin
      rd_vld_reg   <= rd_en;
      sync_out_reg <= rd_vld_reg;
      data_out_reg <= rd_vld_reg ? rd_data : '0;
      case (rd_state_reg)
        RIDLE: begin
          if (full_reg[rd_bank_reg] && !bus.dec_busy) begin
            rd_state_reg <= SEND;
            rd_cnt_reg   <= '0;
          end
        end
        SEND: begin
          // First read cycle: publish frame attributes one cycle ahead of sync.
          if (rd_cnt_reg == '0) begin
            rate_out_reg     <= bank_rate_reg[rd_bank_reg];
            max_iter_out_reg <= bank_iter_reg[rd_bank_reg];
          end
          if (rd_done) begin
            rd_state_reg <= HOLD;
            rd_bank_reg  <= ~rd_bank_reg;
            hold_cnt_reg <= '0;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + CW'(1);
          end
        end
        HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) rd_state_reg <= RIDLE;
          else hold_cnt_reg <= hold_cnt_reg + HW'(1);
        end
        default: rd_state_reg <= RIDLE;
      endcase
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.sync_out     = sync_out_reg;
  assign bus.rate_out     = rate_out_reg;
  assign bus.max_iter_out = max_iter_out_reg;
  assign bus.ovf          = ovf_reg;
  assign bus.frm_err      = frm_err_reg;

endmodule

// File: tb/tb_ldpc_llr_feeder.sv
// tb_ldpc_llr_feeder
// Directed-random bench for ldpc_llr_feeder. A queue of expected frames
// (values, rate, max_iter) is maintained from the feeder's rules; a
// monitor splits the decoder-side stream into bursts for comparison.
// Frame length is reduced so the whole run stays short.
module tb_ldpc_llr_feeder;
  localparam int FL   = 256;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ldpc_llr_feeder_if #(.D_WID(6)) bus ();

  ldpc_llr_feeder #(.D_WID(6), .FRAME_LEN(FL), .AW(8), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // monitor state
  int cycle = 0, cur_len = 0, low_run = 0, sync_total = 0;
  int frm_err_cnt = 0, nz_idle = 0;
  logic prev_sync = 1'b0, prev_rate = 1'b0;
  logic [4:0] prev_iter = '0;
  logic [5:0] got_data[$];
  int got_len[$], got_gap[$], got_start[$];
  logic got_rate[$];
  logic [4:0] got_iter[$];

  // reference model: frames waiting in the buffer, in arrival order
  logic [5:0] exp_data[$];
  logic exp_rate[$];
  logic [4:0] exp_iter[$];
  logic exp_ovf = 1'b0;

  logic [5:0] fr [FL];
  int last_gap, last_start;

  function automatic logic [5:0] stored(input logic [5:0] v);
`ifdef LLR_CLIP_EN
    if (v == 6'b100000) return 6'b100001;
`endif
    return v;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (bus.frm_err === 1'b1) frm_err_cnt++;
      if (bus.sync_out === 1'b1) begin
        if (!prev_sync) begin
          got_gap.push_back(low_run);
          got_rate.push_back(prev_rate);
          got_iter.push_back(prev_iter);
          got_start.push_back(cycle);
          cur_len = 0;
        end
        cur_len++;
        sync_total++;
        low_run = 0;
        got_data.push_back(bus.data_out);
      end else begin
        if (prev_sync) got_len.push_back(cur_len);
        low_run++;
        if (bus.data_out !== 6'd0) nz_idle++;
      end
      prev_sync = (bus.sync_out === 1'b1);
      prev_rate = bus.rate_out;
      prev_iter = bus.max_iter_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_llr(input logic [5:0] v, input logic sof, input logic r,
                         input logic [4:0] it, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) begin
      bus.llr_vld = 1'b0;
      bus.sof_in  = 1'b0;
      bus.llr_in  = 6'($urandom);
      cyc();
    end
    bus.llr_vld = 1'b1;
    bus.sof_in  = sof;
    bus.llr_in  = v;
    bus.rate_in = r;
    bus.max_iter_in = it;
    cyc();
    bus.llr_vld = 1'b0;
    bus.sof_in  = 1'b0;
  endtask

  // Drives fr[0..len-1] as one frame; a complete frame enters the model
  // unless two frames are already waiting, in which case it is dropped.
  task automatic write_frame(input logic r, input logic [4:0] it, input int gap_pct, input int len);
    for (int i = 0; i < len; i++) put_llr(fr[i], (i == 0), r, it, gap_pct);
    if (len == FL) begin
      if (exp_rate.size() >= 2) exp_ovf = 1'b1;
      else begin
        for (int i = 0; i < FL; i++) exp_data.push_back(stored(fr[i]));
        exp_rate.push_back(r);
        exp_iter.push_back(it);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < FL; i++) fr[i] = 6'($urandom);
  endtask

  task automatic wait_bursts(input string tag, input int n, input int budget);
    int k = 0;
    while (got_len.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_burst_seen"}, got_len.size() >= n, 1);
  endtask

  task automatic check_frame(input string tag);
    int len, mism;
    logic r;
    logic [4:0] it;
    logic [5:0] ev [FL];
    logic [5:0] gv;
    if (got_len.size() == 0) return;
    len = got_len.pop_front();
    r = got_rate.pop_front();
    it = got_iter.pop_front();
    last_gap = got_gap.pop_front();
    last_start = got_start.pop_front();
    chk({tag, "_expected_frame"}, exp_rate.size() > 0, 1);
    if (exp_rate.size() == 0) begin
      for (int i = 0; i < len; i++) gv = got_data.pop_front();
      return;
    end
    for (int i = 0; i < FL; i++) ev[i] = exp_data.pop_front();
    mism = 0;
    for (int i = 0; i < len; i++) begin
      gv = got_data.pop_front();
      if (i < FL && gv !== ev[i]) mism++;
    end
    chk({tag, "_len"}, len, FL);
    chk({tag, "_rate"}, r, exp_rate.pop_front());
    chk({tag, "_iter"}, it, exp_iter.pop_front());
    chk({tag, "_data_mismatches"}, mism, 0);
  endtask

  initial begin
    int s0, rel, f0, k;
    logic [5:0] exp0;
    bus.llr_in = '0; bus.llr_vld = 1'b0; bus.sof_in = 1'b0;
    bus.rate_in = 1'b0; bus.max_iter_in = '0; bus.dec_busy = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_sync_out", bus.sync_out, 0);
    chk("rst_rate_out", bus.rate_out, 0);
    chk("rst_max_iter_out", bus.max_iter_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_frm_err", bus.frm_err, 0);
    reset_n = 1'b1;
    cyc();

    // 1: contiguous frame of i mod 64, rate 0, max_iter 20
    for (int i = 0; i < FL; i++) fr[i] = 6'(i % 64);
    write_frame(1'b0, 5'd20, 0, FL);
    wait_bursts("t1", 1, 4 * FL);
    check_frame("t1");
    repeat (10) cyc();

    // 2: gappy write, decoder busy 500 cycles after the frame completes
    bus.dec_busy = 1'b1;
    fill_random();
    write_frame(1'($urandom), 5'($urandom), 50, FL);
    s0 = sync_total;
    repeat (500) cyc();
    chk("t2_no_sync_while_busy", sync_total - s0, 0);
    rel = cycle;
    bus.dec_busy = 1'b0;
    wait_bursts("t2", 1, 4 * FL);
    check_frame("t2");
    chk("t2_start_after_busy", last_start > rel, 1);
    repeat (10) cyc();

    // 3: three back-to-back frames while busy; third must be dropped
    chk("t3_ovf_before", bus.ovf, exp_ovf);
    bus.dec_busy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      write_frame(1'($urandom), 5'($urandom), 0, FL);
    end
    cyc();
    chk("t3_ovf_set", bus.ovf, exp_ovf);
    bus.dec_busy = 1'b0;
    wait_bursts("t3", 2, 6 * FL);
    check_frame("t3_f1");
    check_frame("t3_f2");
    chk("t3_gap_ge_hold_plus1", last_gap >= HOLD + 1, 1);
    chk("t3_ovf_sticky", bus.ovf, exp_ovf);
    repeat (10) cyc();

    // 4: sof reasserted after 100 LLRs
    f0 = frm_err_cnt;
    fill_random();
    write_frame(1'b1, 5'd3, 0, 100);
    fill_random();
    write_frame(1'b0, 5'd17, 20, FL);
    chk("t4_frm_err_pulses", frm_err_cnt - f0, 1);
    wait_bursts("t4", 1, 4 * FL);
    check_frame("t4");
    repeat (10) cyc();

    // 5: reset in the middle of a burst with a second frame queued
    bus.dec_busy = 1'b1;
    fill_random();
    write_frame(1'b1, 5'd29, 0, FL);
    fill_random();
    write_frame(1'b1, 5'd30, 0, FL);
    bus.dec_busy = 1'b0;
    k = 0;
    while (got_start.size() == 0 && k < 4 * FL) begin
      cyc();
      k++;
    end
    chk("t5_burst_started", got_start.size() > 0, 1);
    repeat (40) cyc();
    reset_n = 1'b0;
    cyc();
    chk("t5_sync_out", bus.sync_out, 0);
    chk("t5_data_out", bus.data_out, 0);
    chk("t5_rate_out", bus.rate_out, 0);
    chk("t5_max_iter_out", bus.max_iter_out, 0);
    chk("t5_ovf", bus.ovf, 0);
    chk("t5_frm_err", bus.frm_err, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    got_data.delete(); got_len.delete(); got_gap.delete(); got_start.delete();
    got_rate.delete(); got_iter.delete();
    exp_data.delete(); exp_rate.delete(); exp_iter.delete();
    exp_ovf = 1'b0;
    s0 = sync_total;
    repeat (3 * FL) cyc();
    chk("t5_no_residual_sync", sync_total - s0, 0);
    chk("t5_no_residual_frame", got_start.size(), 0);

    // 6: most negative code at position 0, +31 at position 1
    fill_random();
    fr[0] = 6'b100000;
    fr[1] = 6'd31;
`ifdef LLR_CLIP_EN
    exp0 = 6'b100001;
`else
    exp0 = 6'b100000;
`endif
    write_frame(1'b1, 5'd7, 0, FL);
    wait_bursts("t6", 1, 4 * FL);
    chk("t6_pos0", (got_data.size() > 1) ? got_data[0] : 6'bx, exp0);
    chk("t6_pos1", (got_data.size() > 1) ? got_data[1] : 6'bx, 6'd31);
    check_frame("t6");
    repeat (10) cyc();

    chk("idle_data_out_zero", nz_idle, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ldpc_llr_feeder.md
Name: ldpc_llr_feeder

Overview:
Transmit side of the LDPC decoder input interface (data_in/sync_in/rate/max_iter). It collects bursty soft-decision LLRs from the demapper into a ping-pong frame buffer. Each complete frame is then sent to the decoder as one gap-free burst of FRAME_LEN cycles with the input-valid strobe held high throughout, starting only when the decoder is not busy. Rate and iteration limit are captured per frame and travel with it.

Parameters:
D_WID, 6, LLR width (two's complement), matches decoder data_in
FRAME_LEN, 9216, LLRs per codeword
AW, 14, buffer address width per bank; 2^AW >= FRAME_LEN
HOLD_CYC, 2, idle cycles forced after each burst before busy is sampled again

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
llr_in  in  D_WID  LLR from demapper
llr_vld  in  1  llr_in valid this cycle
sof_in  in  1  first LLR of a frame; qualified by llr_vld
rate_in  in  1  code rate of the frame, sampled with sof_in
max_iter_in  in  5  iteration limit, sampled with sof_in
dec_busy  in  1  decoder busy
data_out  out  D_WID  LLR to decoder data_in
sync_out  out  1  to decoder sync_in; high for exactly FRAME_LEN consecutive cycles per frame
rate_out  out  1  rate of the frame being or last sent
max_iter_out  out  5  max_iter of the frame being or last sent
ovf  out  1  sticky: frame dropped because both banks were full
frm_err  out  1  one-cycle pulse: partial frame discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: data_out=0, sync_out=0, rate_out=0, max_iter_out=0, ovf=0, frm_err=0. Both banks empty. Write FSM in IDLE, read FSM in IDLE. Reset mid-burst ends sync_out on the next edge and discards all buffered data.
- Storage: 2 banks of FRAME_LEN x D_WID, plus per-bank full flag, rate and max_iter.
- Write side:
  - WIDLE: llr_vld with sof_in targets the write bank (wr_bank).
    - If that bank is full: drop the whole frame, set ovf, stay in WIDLE.
    - Otherwise write the LLR at addr 0, latch rate_in/max_iter_in, go to WFILL with addr=1.
  - WFILL: each llr_vld writes one LLR at addr, then addr+1.
    - A write at addr FRAME_LEN-1 sets full[wr_bank], toggles wr_bank and returns to WIDLE.
    - llr_vld with sof_in in WFILL: pulse frm_err, discard the partial frame, restart at addr 0 in the same bank (same bank-full check as WIDLE).
    - llr_vld=0 cycles are gaps; no write occurs.
  - While in WIDLE, llr_vld without sof_in is ignored.
- Read side:
  - RIDLE: when full[rd_bank]=1 and dec_busy=0, go to SEND and start reading at addr 0.
  - SEND: buffer read latency is 1 cycle. data_out/sync_out are registered. The first sync_out=1 comes 2 cycles after leaving RIDLE.
    - rate_out/max_iter_out update from the bank on the cycle before the first sync_out and hold until the next frame.
    - dec_busy is ignored during SEND; the burst is never interrupted.
  - After the FRAME_LEN-th output: sync_out=0 and data_out=0 on the next cycle. Clear full[rd_bank], toggle rd_bank, go to HOLD.
  - HOLD: wait HOLD_CYC cycles, then go to RIDLE. This guarantees at least HOLD_CYC+1 low cycles of sync_out between frames.
- Simultaneous events:
  - A write completing a bank in the same cycle as the read side clearing the other bank: both take effect.
  - Writing a bank the read side is clearing in the same cycle counts as empty for the overflow check only from the next cycle. No same-cycle bypass.
- Order: frames are sent strictly in arrival order. LLR values pass through bit-exact, except as described under LLR_CLIP_EN.

Optional Feature:
- Macro: LLR_CLIP_EN.
- Defined: llr_in equal to the most negative code (-2^(D_WID-1), i.e. -32) is written as -(2^(D_WID-1)-1), i.e. -31. This keeps the range symmetric for the decoder's min-sum sign/magnitude. All other values are unchanged.
- Undefined: no clipping; values are stored exactly.

Test Plan:
1. Reset, then one contiguous frame of 9216 LLRs with values i mod 64, rate_in=0, max_iter_in=20, dec_busy=0 -> sync_out high exactly 9216 consecutive cycles; data_out sequence equals input; max_iter_out=20, rate_out=0 before the first sync.
2. Frame written with random llr_vld gaps (50% duty), dec_busy=1 held for 500 cycles after the frame completes -> no sync_out until dec_busy falls; then a single gap-free 9216-cycle burst.
3. Three back-to-back frames with dec_busy=1 throughout the writes -> frames 1 and 2 stored; frame 3 dropped with ovf=1 (sticky); after busy clears, frames 1 then 2 emitted, separated by >=3 low sync cycles.
4. sof_in reasserted after 100 LLRs of a frame -> frm_err pulses 1 cycle; the emitted frame contains only the second frame's data.
5. reset_n=0 for 1 cycle in the middle of a burst -> sync_out=0 the next cycle; all outputs at reset values; no residual frame emitted afterwards.
6. LLR_CLIP_EN defined, input -32 at position 0 and +31 at position 1 -> data_out -31 and +31; without the macro -> -32 and +31.
